// File: rtl/sync_async_tx_m.sv
// Clocked-to-asynchronous transmit bridge: a valid/ready FIFO drains into a
// 4-phase bundled-data req/ack handshake toward the first async pipeline stage.
module sync_async_tx_m #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_data,
    output logic                         a_req,
    input  logic                         a_ack,
    output logic [WIDTH-1:0]             a_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         proto_err
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
    localparam logic [SCW-1:0] SETUP_LOAD = SCW'(SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t                  state;
    logic [WIDTH-1:0]        mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [SYNC_STAGES-1:0]  ack_sync;
    logic [SCW-1:0]          setup_cnt;
    logic                    ack_s;
    logic                    push;
    logic                    pop;

    // Full-ness comes from the stored count only, so a same-edge pop never
    // opens a slot for a push.
    assign s_ready = (count != FULL_COUNT);
    assign push    = s_valid && s_ready;
    assign pop     = (state == IDLE) && (count != '0);
    assign ack_s   = ack_sync[SYNC_STAGES-1];
    assign busy    = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], a_ack};
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and leaving it unreset keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // a_data is loaded only on the IDLE pop, so it holds from the a_req rise
    // through the whole return-to-zero phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_req     <= 1'b0;
            a_data    <= '0;
            setup_cnt <= '0;
            proto_err <= 1'b0;
        end else begin
            if ((state == IDLE || state == SETUP) && ack_s) begin
                proto_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        a_data    <= mem[rd_ptr];
                        setup_cnt <= SETUP_LOAD;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == '0) begin
                        a_req <= 1'b1;
                        state <= WAIT_HI;
                    end else begin
                        setup_cnt <= setup_cnt - 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (ack_s) begin
                        a_req <= 1'b0;
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_async_tx_m.sv
// Randomized self-checking bench for sync_async_tx_m: an ordered expected-word
// queue plus an auto-responding 4-phase async stage model.
module tb_sync_async_tx_m;

    localparam int WIDTH        = 32;
    localparam int DEPTH        = 4;
    localparam int SYNC_STAGES  = 2;
    localparam int SETUP_CYCLES = 1;
    localparam int CW           = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             a_req;
    logic             a_ack;
    logic [WIDTH-1:0] a_data;
    logic [CW-1:0]    count;
    logic             busy;
    logic             proto_err;

    logic ack_resp;
    logic ack_force;
    logic ack_stall;
    logic ack_rand;
    int   ack_delay;

    int n_checks;
    int n_errors;
    int cyc;
    int rises;
    int falls;
    int rise_cyc;
    int push_cyc;
    logic [WIDTH-1:0] exp_q[$];

    assign a_ack = ack_resp | ack_force;

    sync_async_tx_m #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC_STAGES),
        .SETUP_CYCLES(SETUP_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .a_req(a_req),
        .a_ack(a_ack),
        .a_data(a_data),
        .count(count),
        .busy(busy),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Async stage model: follows a_req after ack_delay clocks unless stalled.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        ack_resp = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                ack_resp = 1'b0;
                wait_cnt = 0;
            end else if (!ack_stall && (a_req !== ack_resp)) begin
                if (wait_cnt >= ack_delay) begin
                    ack_resp = a_req;
                    wait_cnt = 0;
                    if (ack_rand) ack_delay = $urandom_range(0, 4);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Output monitor: each request must carry the next queued word, held stable.
    initial begin
        logic             prev_req;
        logic [WIDTH-1:0] held;
        prev_req = 1'b0;
        held     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                if (a_req && !prev_req) begin
                    rises++;
                    rise_cyc = cyc;
                    held     = a_data;
                    check("word_expected_at_req", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("word_order", a_data, exp_q.pop_front());
                end else if (a_req && prev_req) begin
                    check("a_data_stable", a_data, held);
                end
                if (a_req) check("busy_with_req", 32'(busy), 32'd1);
                if (!a_req && prev_req) falls++;
                prev_req = a_req;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_word(input logic [WIDTH-1:0] w, output bit acc);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        acc     = s_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q.push_back(w);
            push_cyc = cyc;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (!busy && count == '0 && !a_req && !a_ack) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit acc;
        bit found;
        int r0;
        int f0;
        n_checks  = 0;
        n_errors  = 0;
        rises     = 0;
        falls     = 0;
        rise_cyc  = 0;
        push_cyc  = 0;
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        ack_force = 1'b0;
        ack_stall = 1'b0;
        ack_rand  = 1'b0;
        ack_delay = 3;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_a_req", 32'(a_req), 32'd0);
            check("idle_s_ready", 32'(s_ready), 32'd1);
            check("idle_count", 32'(count), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        check("reset_a_data", a_data, 32'd0);
        check("reset_proto_err", 32'(proto_err), 32'd0);

        // Single word latency and one full 4-phase cycle
        r0 = rises;
        f0 = falls;
        push_word(32'hDEADBEEF, acc);
        check("first_push_accepted", 32'(acc), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rises != r0) found = 1'b1;
        end
        check("req_seen", 32'(found), 32'd1);
        check("req_latency", 32'(rise_cyc - push_cyc), 32'(1 + SETUP_CYCLES));
        wait_drain(100);
        check("single_rises", 32'(rises - r0), 32'd1);
        check("single_falls", 32'(falls - f0), 32'd1);
        check("single_busy_done", 32'(busy), 32'd0);

        // Stalled ack: FIFO fills behind one in-flight word
        ack_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_word(32'h1000 + 32'(i), acc);
            check("stall_push_accepted", 32'(acc), 32'd1);
        end
        @(negedge clk);
        check("stall_count_full", 32'(count), 32'(DEPTH));
        check("stall_s_ready", 32'(s_ready), 32'd0);
        push_word(32'h2000, acc);
        check("sixth_push_refused", 32'(acc), 32'd0);
        check("stall_count_held", 32'(count), 32'(DEPTH));
        ack_delay = 2;
        ack_stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (count == CW'(DEPTH - 1)) found = 1'b1;
        end
        check("first_pop_seen", 32'(found), 32'd1);
        check("ready_after_pop", 32'(s_ready), 32'd1);
        wait_drain(300);

        // Push coinciding with pop at count=2
        ack_stall = 1'b1;
        ack_delay = 1;
        push_word(32'h3000, acc);
        push_word(32'h3001, acc);
        push_word(32'h3002, acc);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (a_req) found = 1'b1;
        end
        check("pp_req_seen", 32'(found), 32'd1);
        check("pp_count_before", 32'(count), 32'd2);
        ack_stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        check("pp_idle_seen", 32'(found), 32'd1);
        check("pp_count_at_idle", 32'(count), 32'd2);
        s_valid = 1'b1;
        s_data  = 32'h3003;
        acc     = s_ready;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(32'h3003);
        s_valid = 1'b0;
        check("pp_push_accepted", 32'(acc), 32'd1);
        check("pp_count_same", 32'(count), 32'd2);
        check("pp_busy_after_pop", 32'(busy), 32'd1);
        wait_drain(300);

        // Random traffic with random ack delays
        ack_rand = 1'b1;
        r0 = rises;
        for (int i = 0; i < 64; i++) begin
            logic [WIDTH-1:0] w;
            w = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) push_word(w, acc);
            check("rand_push_accepted", 32'(acc), 32'd1);
        end
        wait_drain(2000);
        check("rand_word_count", 32'(rises - r0), 32'd64);
        ack_rand  = 1'b0;
        ack_delay = 2;

        // Reset in the middle of a handshake with three words buffered
        ack_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_word(32'h4000 + 32'(i), acc);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (a_req && count == CW'(3)) found = 1'b1;
        end
        check("mid_reset_setup", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_drops_req", 32'(a_req), 32'd0);
        check("reset_clears_count", 32'(count), 32'd0);
        check("reset_s_ready", 32'(s_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ack_stall = 1'b0;
        r0 = rises;
        push_word(32'hCAFEF00D, acc);
        check("post_reset_push", 32'(acc), 32'd1);
        wait_drain(100);
        check("post_reset_word", 32'(rises - r0), 32'd1);

        // Spurious ack while idle
        r0 = rises;
        @(negedge clk);
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        ack_force = 1'b0;
        check("proto_err_set", 32'(proto_err), 32'd1);
        repeat (10) @(negedge clk);
        check("proto_err_sticky", 32'(proto_err), 32'd1);
        check("no_req_on_spurious", 32'(rises - r0), 32'd0);
        push_word(32'h5A5A5A5A, acc);
        wait_drain(100);
        check("tx_after_proto_err", 32'(rises - r0), 32'd1);
        check("proto_err_still_set", 32'(proto_err), 32'd1);
        apply_reset();
        @(negedge clk);
        check("proto_err_cleared", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
